instruction_fetch_unit: RTL

Parametrised fetch front end for the MIPS core: holds the fetch PC, issues reads to the instruction memory, and buffers returned instructions with their PCs in a small prefetch queue. Decode drains the queue with a valid/ready handshake. A single redirect port loads the PC for every control transfer: branch, jump, JR, and PC from memory or ALU. The redirect also flushes all queued and in-flight fetches. The block replaces the fixed PC/IR pair, so fetch runs ahead of decode stalls and wrong-path instructions are discarded without nop injection.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/instruction_fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_DATA_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [FETCH_DATA_W-1:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; clear outranks push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  fetch_entry_t     push_data_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i && !rst) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, instruction memory reads and prefetch queue for the MIPS core.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter  int                DATA_W      = FETCH_DATA_W,
  parameter  int                IM_ADDR_W   = 12,
  parameter  int                QUEUE_DEPTH = 4,
  parameter  logic [DATA_W-1:0] RESET_PC    = DATA_W'(DEFAULT_RESET_PC),
  localparam int                CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [DATA_W-1:0]    redirect_pc,
  output logic                 im_cs,
  output logic                 im_rd,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0]    im_rdata,
  output logic                 if_valid,
  input  logic                 id_ready,
  output logic [DATA_W-1:0]    if_ir,
  output logic [DATA_W-1:0]    if_pc,
  output logic [DATA_W-1:0]    if_pc4,
  output logic [DATA_W-1:0]    if_se16,
  output logic [CNT_W-1:0]     ifq_count
);

  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] tag_pc_q, tag_pc_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] issue_pc;
  logic [DATA_W-1:0] head_pc, head_ir;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    occupancy;
  logic              issue, ret_valid, pop_hs, push, q_pop;
  logic              q_full, q_empty, bypass_hit;
  fetch_entry_t      push_entry, head_entry;

  // A redirect issues unconditionally since it also empties the queue.
  assign issue_pc  = redirect_valid ? (redirect_pc & ~DATA_W'(3)) : fetch_pc_q;
  assign ret_valid = inflight_q && !redirect_valid && !rst;
  assign pop_hs    = if_valid && id_ready;
  assign occupancy = {1'b0, q_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop_hs);
  assign issue     = !rst && (redirect_valid || (occupancy < (CNT_W+1)'(QUEUE_DEPTH)));
  assign im_cs     = issue;
  assign im_rd     = issue;
  assign im_addr   = issue_pc[IM_ADDR_W-1:0];

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = ret_valid && q_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign push            = ret_valid && !(bypass_hit && id_ready);
  assign q_pop           = id_ready && !q_empty && !rst;
  assign push_entry.pc    = FETCH_DATA_W'(tag_pc_q);
  assign push_entry.instr = FETCH_DATA_W'(im_rdata);

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (q_pop),
    .clear_i     (redirect_valid),
    .push_data_i (push_entry),
    .head_o      (head_entry),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_comb begin
    head_pc = '0;
    head_ir = '0;
    if (!rst && !q_empty) begin
      head_pc = DATA_W'(head_entry.pc);
      head_ir = DATA_W'(head_entry.instr);
    end else if (!rst && bypass_hit) begin
      head_pc = tag_pc_q;
      head_ir = im_rdata;
    end
  end

  assign if_valid  = !rst && (!q_empty || bypass_hit);
  assign if_pc     = head_pc;
  assign if_ir     = head_ir;
  assign if_pc4    = if_valid ? head_pc + DATA_W'(PC_STEP) : '0;
  assign if_se16   = {{(DATA_W-16){head_ir[15]}}, head_ir[15:0]};
  assign ifq_count = q_count;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue;
    if (issue) begin
      fetch_pc_d = issue_pc + DATA_W'(PC_STEP);
      tag_pc_d   = issue_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
    end
  end

  logic unused_full;
  assign unused_full = q_full;

endmodule
